// File: rtl/uart_tx_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_pkg
// Shared types and defaults for the UART transmit arbiter and its helpers.
//   arb_state_e       : arbiter FSM encoding (2 bits)
//   DEF_*             : default parameter values
//   bits_for(n)       : counter width able to hold 0..n (never below 1 bit)
// ----------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  localparam int DEF_NUM_REQ      = 2;
  localparam int DEF_BUSY_TIMEOUT = 64;
  localparam int DEF_MAX_RETRY    = 2;

  function automatic int bits_for(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker. Scans i_req starting at i_ptr and
// wrapping modulo N; returns the first set request as one-hot and index.
//   i_req [N-1:0]  : request vector
//   i_ptr [IW-1:0] : highest-priority position this cycle (must be < N)
//   o_gnt [N-1:0]  : one-hot grant (all zero when nothing requested)
//   o_idx [IW-1:0] : index of the granted request
//   o_any          : at least one request present
// ----------------------------------------------------------------------------
module rr_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int w_pos;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = 0;
    for (int k = 0; k < N; k++) begin
      // rotated position, wrapped without a modulo so N need not be 2^n
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      if (!o_any && i_req[w_pos]) begin
        o_any        = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = IW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_sender between NUM_REQ byte producers. Round-robin grant,
// byte capture, one-cycle tx_en launch, then follows the sender's idle flag
// through busy -> idle before the next grant. A launch the sender never
// acknowledges is retried MAX_RETRY times, then dropped with err_drop.
//   clk, reset          : system clock, synchronous active-high reset
//   req_valid[NUM_REQ]  : per-requester byte-valid level
//   req_data[8*NUM_REQ] : byte i at [8i+7:8i]
//   req_ready[NUM_REQ]  : one-cycle one-hot accept pulse
//   tx_status           : sender idle flag (1 = idle), baud-clock domain
//   tx_data[8]          : byte to the sender, stable from grant to IDLE
//   tx_en               : launch pulse to the sender
//   busy                : FSM not in IDLE
//   grant_id            : index of the last granted requester
//   err_drop            : one-cycle pulse when a byte is abandoned
// ----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       tx_status,
  output logic [7:0]                 tx_data,
  output logic                       tx_en,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err_drop
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int CNT_W = bits_for(BUSY_TIMEOUT);
  localparam int RTY_W = bits_for(MAX_RETRY);

  arb_state_e         r_state, w_state_nxt;
  logic [IW-1:0]      r_ptr, w_ptr_nxt;
  logic [IW-1:0]      r_grant_id, w_grant_id_nxt;
  logic [7:0]         r_tx_data, w_tx_data_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [RTY_W-1:0]   r_retry, w_retry_nxt;

  logic               r_sync1, r_sync2;
  logic [1:0]         r_primed;
  logic               w_sts;

  logic [NUM_REQ-1:0] w_pick_gnt;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_any;

  logic [NUM_REQ-1:0] w_req_ready;
  logic               w_tx_en;
  logic               w_err_drop;

  assign w_sts = r_sync2;

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Sequential state. The synchroniser resets to "idle", which would be a
  // lie if the sender is mid-frame when reset hits; r_primed blocks grants
  // until two real samples of tx_status have flushed the reset value out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_tx_data  <= '0;
      r_cnt      <= '0;
      r_retry    <= '0;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_primed   <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_cnt      <= w_cnt_nxt;
      r_retry    <= w_retry_nxt;
      r_sync1    <= tx_status;
      r_sync2    <= r_sync1;
      r_primed   <= {r_primed[0], 1'b1};
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_grant_id_nxt = r_grant_id;
    w_tx_data_nxt  = r_tx_data;
    w_cnt_nxt      = r_cnt;
    w_retry_nxt    = r_retry;
    w_req_ready    = '0;
    w_tx_en        = 1'b0;
    w_err_drop     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_any && w_sts && r_primed[1]) begin
          w_req_ready    = w_pick_gnt;
          w_grant_id_nxt = w_pick_idx;
          for (int i = 0; i < NUM_REQ; i++)
            if (w_pick_gnt[i]) w_tx_data_nxt = req_data[8*i +: 8];
          w_ptr_nxt      = (w_pick_idx == IW'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
          w_state_nxt    = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        w_tx_en     = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_WAIT_BUSY;
      end

      // Sender acknowledgement beats the timeout when both land together.
      ST_WAIT_BUSY: begin
        if (!w_sts) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_cnt == CNT_W'(BUSY_TIMEOUT)) begin
          if (r_retry < RTY_W'(MAX_RETRY)) begin
            w_retry_nxt = r_retry + 1'b1;
            w_state_nxt = ST_LAUNCH;
          end else begin
            w_err_drop  = 1'b1;
            w_retry_nxt = '0;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      // A started frame always finishes, so no timeout here.
      ST_WAIT_DONE: begin
        if (w_sts) begin
          w_retry_nxt = '0;
          w_state_nxt = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign req_ready = w_req_ready;
  assign tx_en     = w_tx_en;
  assign err_drop  = w_err_drop;
  assign tx_data   = r_tx_data;
  assign grant_id  = r_grant_id;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NREQ  = 2;
  localparam int TO    = 64;
  localparam int MR    = 2;
  localparam int FRAME = 160;

  logic                     clk;
  logic                     reset;
  logic [NREQ-1:0]          req_valid;
  logic [8*NREQ-1:0]        req_data;
  logic [NREQ-1:0]          req_ready;
  logic                     tx_status;
  logic [7:0]               tx_data;
  logic                     tx_en;
  logic                     busy;
  logic [$clog2(NREQ)-1:0]  grant_id;
  logic                     err_drop;

  logic auto_snd, snd_status, man_status;
  assign tx_status = auto_snd ? snd_status : man_status;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .BUSY_TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_status (tx_status),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .busy      (busy),
    .grant_id  (grant_id),
    .err_drop  (err_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // event monitor
  int n_en = 0, n_rdy = 0, n_drop = 0, drop_cyc = 0;
  logic [7:0] en_data[$];
  int         en_gid[$];
  int         en_cyc[$];
  always @(negedge clk) begin
    if (tx_en) begin
      n_en <= n_en + 1;
      en_data.push_back(tx_data);
      en_gid.push_back(int'(grant_id));
      en_cyc.push_back(cyc);
    end
    if (|req_ready) n_rdy <= n_rdy + 1;
    if (err_drop) begin
      n_drop   <= n_drop + 1;
      drop_cyc <= cyc;
    end
  end

  // modelled sender: goes busy 3 cycles after a launch, idle FRAME later
  int snd_rise = 0;
  initial begin
    snd_status = 1'b1;
    forever begin
      @(negedge clk);
      if (auto_snd && tx_en) begin
        repeat (3) @(posedge clk);
        #1 snd_status = 1'b0;
        repeat (FRAME) @(posedge clk);
        #1 snd_status = 1'b1;
        snd_rise = cyc;
      end
    end
  end

  int n_err = 0, n_chk = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag, input int exp, output int c);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (|req_ready) begin
        got = 1'b1;
        break;
      end
    end
    c = cyc;
    chk({tag, "_seen"}, int'(got), 1);
    chk(tag, int'(req_ready), exp);
  endtask

  task automatic wait_idle(input string tag);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!busy) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, int'(got), 1);
  endtask

  int c0, c1, rise, b_en, b_rdy, b_drop, b_q;
  bit got;

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0;
    man_status = 1'b1; auto_snd = 1'b0;
    tick(2);
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_tx_en",     int'(tx_en),     0);
    chk("rst_tx_data",   int'(tx_data),   0);
    chk("rst_busy",      int'(busy),      0);
    chk("rst_grant_id",  int'(grant_id),  0);
    chk("rst_err_drop",  int'(err_drop),  0);
    tick(1);
    reset = 1'b0;
    tick(3);

    // single request
    auto_snd = 1'b1;
    b_en = n_en; b_drop = n_drop;
    req_data = 16'h00A5; req_valid = 2'b01;
    wait_ready("t1_ready", 1, c0);
    tick(1);
    req_valid = '0;
    @(negedge clk);
    chk("t1_tx_en",      int'(tx_en),   1);
    chk("t1_en_latency", cyc - c0,      1);
    chk("t1_tx_data",    int'(tx_data), 8'hA5);
    chk("t1_busy",       int'(busy),    1);
    chk("t1_ready_1cyc", int'(req_ready), 0);
    wait_idle("t1_idle");
    c1 = cyc;
    chk("t1_idle_lag", int'((c1 - snd_rise >= 2) && (c1 - snd_rise <= 3)), 1);
    tick(1);
    chk("t1_en_count",   n_en - b_en,     1);
    chk("t1_no_drop",    n_drop - b_drop, 0);

    // pointer fairness, then contention with both held
    b_q = en_data.size();
    req_data = {8'h22, 8'h11}; req_valid = 2'b10;
    wait_ready("t3_req1", 2, c0);
    tick(1);
    req_valid = 2'b11;
    wait_ready("t3_fair_req0", 1, c0);
    got = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk); #1;
      if (en_data.size() >= b_q + 7) begin
        got = 1'b1;
        break;
      end
    end
    chk("t2_six_frames", int'(got), 1);
    tick(1);
    req_valid = '0;
    if (got) begin
      chk("t3_req1_data", int'(en_data[b_q]), 8'h22);
      chk("t3_req1_gid",  en_gid[b_q], 1);
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("t2_data%0d", k), int'(en_data[b_q+1+k]), (k % 2 == 0) ? 8'h11 : 8'h22);
        chk($sformatf("t2_gid%0d", k),  en_gid[b_q+1+k], k % 2);
      end
    end
    wait_idle("t2_idle");

    // external busy while idle
    tick(1);
    auto_snd = 1'b0; man_status = 1'b0;
    tick(3);
    b_rdy = n_rdy; b_en = n_en;
    req_data = {8'h77, 8'h3C}; req_valid = 2'b01;
    tick(30);
    chk("t4_no_ready", n_rdy - b_rdy, 0);
    chk("t4_no_en",    n_en - b_en,   0);
    chk("t4_idle",     int'(busy),    0);
    man_status = 1'b1; rise = cyc;
    wait_ready("t4_ready", 1, c0);
    chk("t4_ready_lag", c0 - rise, 2);
    tick(1);
    req_valid = '0;
    @(negedge clk);
    chk("t4_tx_en",   int'(tx_en),   1);
    chk("t4_tx_data", int'(tx_data), 8'h3C);
    tick(3);
    man_status = 1'b0;
    tick(10);
    chk("t4_busy_frame", int'(busy), 1);

    // reset mid-frame; both valid so the pointer reset is visible
    req_data = {8'h77, 8'hC3}; req_valid = 2'b11;
    reset = 1'b1;
    tick(1);
    chk("t5_req_ready", int'(req_ready), 0);
    chk("t5_tx_en",     int'(tx_en),     0);
    chk("t5_tx_data",   int'(tx_data),   0);
    chk("t5_busy",      int'(busy),      0);
    chk("t5_grant_id",  int'(grant_id),  0);
    chk("t5_err_drop",  int'(err_drop),  0);
    reset = 1'b0;
    b_rdy = n_rdy; b_en = n_en; b_drop = n_drop;
    tick(20);
    chk("t5_no_ready", n_rdy - b_rdy, 0);
    chk("t5_no_en",    n_en - b_en,   0);
    man_status = 1'b1; rise = cyc;
    wait_ready("t5_ready_req0", 1, c0);
    chk("t5_ready_lag", c0 - rise, 2);
    tick(1);
    req_valid = '0;
    @(negedge clk);
    chk("t5_tx_en",   int'(tx_en),   1);
    chk("t5_tx_data", int'(tx_data), 8'hC3);
    #1;
    b_q = en_cyc.size() - 1;

    // dead sender: tx_status stays idle
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (err_drop) begin
        got = 1'b1;
        break;
      end
    end
    chk("t6_err_drop_seen", int'(got), 1);
    tick(1);
    chk("t6_en_count",   n_en - b_en,     3);
    chk("t6_drop_count", n_drop - b_drop, 1);
    chk("t6_idle",       int'(busy),      0);
    if (en_cyc.size() >= b_q + 3) begin
      chk("t6_gap1",     en_cyc[b_q+1] - en_cyc[b_q],   66);
      chk("t6_gap2",     en_cyc[b_q+2] - en_cyc[b_q+1], 66);
      chk("t6_drop_at",  drop_cyc - en_cyc[b_q+2],      65);
      chk("t6_data1",    int'(en_data[b_q+1]), 8'hC3);
      chk("t6_data2",    int'(en_data[b_q+2]), 8'hC3);
    end
    tick(80);
    chk("t6_no_more_en",   n_en - b_en,     3);
    chk("t6_no_more_drop", n_drop - b_drop, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
